word_to_byte_sizer: RTL and testbench

- Converts 32-bit word accesses from a wide initiator (CPU/DMA) into sequential byte accesses on an 8-bit memory or peripheral port.
- Complements the existing byte-to-word sizer path, covering the opposite width direction.
- Sits between the 32-bit system bus and the byte-wide SRAM/register space.
- Honours byte enables, supports slave wait states via ack, and has an optional ack timeout.

---
 rtl/word_to_byte_sizer_pkg.sv | 47 ++++
 rtl/word_to_byte_sizer_timeout_ctr.sv | 31 +++
 rtl/word_to_byte_sizer.sv | 171 +++++++++++++++++
 tb/tb_word_to_byte_sizer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_to_byte_sizer_pkg.sv
// Shared definitions for the word-to-byte sizer: FSM encoding, lane width and
// the byte-enable lane walker used to pick the next enabled byte lane.
package word_to_byte_sizer_pkg;

    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BYTE = 3'b010,
        DONE = 3'b100
    } state_e;

    typedef struct packed {
        logic              none;
        logic [LANE_W-1:0] lane;
    } lane_sel_t;

    function automatic lane_sel_t first_lane(input logic [NUM_LANES-1:0] be);
        lane_sel_t r;
        r.none = 1'b1;
        r.lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (be[i]) begin
                r.none = 1'b0;
                r.lane = LANE_W'(i);
            end
        end
        return r;
    endfunction

    // Lowest enabled lane strictly above the current one; none=1 when exhausted.
    function automatic lane_sel_t next_lane(input logic [NUM_LANES-1:0] be,
                                            input logic [LANE_W-1:0]    lane);
        lane_sel_t r;
        r.none = 1'b1;
        r.lane = lane;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (be[i] && (i > int'(lane))) begin
                r.none = 1'b0;
                r.lane = LANE_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/word_to_byte_sizer_timeout_ctr.sv
// Per-byte ack timeout: loads CYCLES-1 on clear, counts down while enabled,
// and flags expiry once the final permitted wait cycle is reached.
module sizer_timeout_ctr
    import word_to_byte_sizer_pkg::*;
#(
    parameter int CYCLES = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= CW'(CYCLES - 1);
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/word_to_byte_sizer.sv
// Splits 32-bit word accesses into ascending byte accesses on an 8-bit slave
// port, honouring byte enables, slave wait states and an optional ack timeout.
module word_to_byte_sizer
    import word_to_byte_sizer_pkg::*;
#(
    parameter int ADR_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 master_sel_i,
    input  logic [ADR_WIDTH-1:0] master_adr_i,
    input  logic                 master_we_i,
    input  logic [3:0]           master_be_i,
    input  logic [31:0]          master_dat_i,
    output logic [31:0]          master_dat_o,
    output logic                 master_ack_o,
    output logic                 master_err_o,
    output logic                 slave_sel_o,
    output logic [ADR_WIDTH-1:0] slave_adr_o,
    output logic                 slave_we_o,
    input  logic [7:0]           slave_dat_i,
    output logic [7:0]           slave_dat_o,
    input  logic                 slave_ack_i
);

    state_e               state_q, state_d;
    logic [ADR_WIDTH-3:0] base_q, base_d;
    logic                 we_q, we_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdat_q, wdat_d;
    logic [31:0]          rdat_q, rdat_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 pend_q, pend_d;
    logic                 err_q, err_d;
    logic                 ctrClear, ctrEnable, ctrExpired;
    lane_sel_t            firstSel, nextSel;
    logic                 unused_adr;

    assign unused_adr = ^master_adr_i[1:0];
    assign firstSel   = first_lane(master_be_i);
    assign nextSel    = next_lane(be_q, lane_q);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            sizer_timeout_ctr #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
                .clk_i     (clk_i),
                .reset_ni  (reset_ni),
                .clear_i   (ctrClear),
                .enable_i  (ctrEnable),
                .expired_o (ctrExpired)
            );
        end else begin : g_no_timeout
            logic unused_ctr;
            assign unused_ctr = ctrClear ^ ctrEnable;
            assign ctrExpired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            lane_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            lane_q  <= lane_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // pend_q splits BYTE into the active slave cycle and a one-cycle gap after
    // each ack, which keeps slave_sel_o free of any path from slave_ack_i.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        we_d      = we_q;
        be_d      = be_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        lane_d    = lane_q;
        pend_d    = pend_q;
        err_d     = err_q;
        ctrClear  = 1'b0;
        ctrEnable = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (master_sel_i) begin
                    base_d   = master_adr_i[ADR_WIDTH-1:2];
                    we_d     = master_we_i;
                    be_d     = master_be_i;
                    wdat_d   = master_dat_i;
                    rdat_d   = '0;
                    err_d    = 1'b0;
                    lane_d   = firstSel.lane;
                    ctrClear = 1'b1;
                    if (firstSel.none) begin
                        state_d = DONE;
                    end else begin
                        state_d = BYTE;
                        pend_d  = 1'b1;
                    end
                end
            end
            BYTE: begin
                if (pend_q) begin
                    if (slave_ack_i) begin
                        if (!we_q) begin
                            rdat_d[{lane_q, 3'b000} +: 8] = slave_dat_i;
                        end
                        pend_d = 1'b0;
                    end else if (ctrExpired) begin
                        pend_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        ctrEnable = 1'b1;
                    end
                end else if (!master_sel_i) begin
                    state_d = IDLE;
                end else if (nextSel.none) begin
                    state_d = DONE;
                end else begin
                    lane_d   = nextSel.lane;
                    pend_d   = 1'b1;
                    ctrClear = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        slave_sel_o  = 1'b0;
        slave_adr_o  = '0;
        slave_we_o   = 1'b0;
        slave_dat_o  = '0;
        master_ack_o = 1'b0;
        master_err_o = 1'b0;
        if ((state_q == BYTE) && pend_q) begin
            slave_sel_o = 1'b1;
            slave_adr_o = {base_q, lane_q};
            slave_we_o  = we_q;
            slave_dat_o = wdat_q[{lane_q, 3'b000} +: 8];
        end
        if (state_q == DONE) begin
            master_ack_o = master_sel_i;
            master_err_o = err_q & master_sel_i;
        end
    end

    assign master_dat_o = rdat_q;

endmodule

// File: tb/tb_word_to_byte_sizer.sv
// Self-checking bench for word_to_byte_sizer: byte-wide slave memory model,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_word_to_byte_sizer;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        master_sel_i;
    logic [15:0] master_adr_i;
    logic        master_we_i;
    logic [3:0]  master_be_i;
    logic [31:0] master_dat_i;
    logic [31:0] master_dat_o;
    logic        master_ack_o;
    logic        master_err_o;
    logic        slave_sel_o;
    logic [15:0] slave_adr_o;
    logic        slave_we_o;
    logic [7:0]  slave_dat_i;
    logic [7:0]  slave_dat_o;
    logic        slave_ack_i;

    word_to_byte_sizer #(.ADR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .master_sel_i (master_sel_i),
        .master_adr_i (master_adr_i),
        .master_we_i  (master_we_i),
        .master_be_i  (master_be_i),
        .master_dat_i (master_dat_i),
        .master_dat_o (master_dat_o),
        .master_ack_o (master_ack_o),
        .master_err_o (master_err_o),
        .slave_sel_o  (slave_sel_o),
        .slave_adr_o  (slave_adr_o),
        .slave_we_o   (slave_we_o),
        .slave_dat_i  (slave_dat_i),
        .slave_dat_o  (slave_dat_o),
        .slave_ack_i  (slave_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] dat;
        int          waitCyc;
        int          expCycles;
        logic [31:0] expRdata;
    } vec_t;

    bit [7:0]    slaveMem [65536];
    bit [7:0]    refMem   [65536];
    int          slaveWait = 0;
    bit          slaveMute = 1'b0;
    int          waitCnt   = 0;
    logic [24:0] slaveLog [$];
    int          nCompared = 0;
    int          nMismatched = 0;

    // Byte slave: acks after slaveWait wait cycles, logs every completed byte.
    assign slave_ack_i = slave_sel_o && !slaveMute && (waitCnt >= slaveWait);
    assign slave_dat_i = slaveMem[slave_adr_o];

    always @(posedge clk) begin
        if (slave_sel_o && !slave_ack_i) waitCnt <= waitCnt + 1;
        else                             waitCnt <= 0;
        if (slave_sel_o && slave_ack_i) begin
            slaveLog.push_back({slave_adr_o, slave_we_o, slave_we_o ? slave_dat_o : slave_dat_i});
            if (slave_we_o) slaveMem[slave_adr_o] <= slave_dat_o;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    function automatic int modelCycles(input logic [3:0] be, input int waitCyc);
        return (be == 4'h0) ? 1 : 1 + $countones(be) * (waitCyc + 2);
    endfunction

    function automatic logic [31:0] modelRead(input logic [15:0] adr, input logic [3:0] be);
        logic [31:0] r = '0;
        for (int l = 0; l < 4; l++)
            if (be[l]) r[8*l +: 8] = refMem[{adr[15:2], 2'(l)}];
        return r;
    endfunction

    task automatic applyStimulus(input logic [15:0] adr, input logic we, input logic [3:0] be,
                                 input logic [31:0] dat, input int waitCyc,
                                 output int cycles, output logic [31:0] rdata, output logic err,
                                 output int glitches, output int selCycles);
        logic        prevSel = 1'b0;
        logic        prevAck = 1'b0;
        logic [15:0] prevAdr = '0;
        cycles = 0; rdata = '0; err = 1'b0; glitches = 0; selCycles = 0;
        slaveWait = waitCyc;
        @(posedge clk); #1;
        master_sel_i = 1'b1; master_adr_i = adr; master_we_i = we;
        master_be_i  = be;   master_dat_i = dat;
        @(posedge clk); #1;
        master_adr_i = 16'($urandom); master_we_i = ~we;
        master_be_i  = 4'($urandom);  master_dat_i = $urandom;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (prevSel && !prevAck && (!slave_sel_o || slave_adr_o != prevAdr)) glitches++;
            if (slave_sel_o) selCycles++;
            if (master_ack_o) begin
                cycles = c; rdata = master_dat_o; err = master_err_o;
                break;
            end
            prevSel = slave_sel_o; prevAck = slave_ack_i; prevAdr = slave_adr_o;
        end
        master_sel_i = 1'b0;
    endtask

    // Runs one transfer and checks latency, data, err, sel stability and the slave byte sequence.
    task automatic checkTransfer(input string name, input logic [15:0] adr, input logic we,
                                 input logic [3:0] be, input logic [31:0] dat, input int waitCyc,
                                 input int expCycles, input logic [31:0] expRdata);
        int          cycles, glitches, selCycles, diffs, logStart;
        logic [31:0] rdata;
        logic        err;
        logic [24:0] expLog [$];
        for (int l = 0; l < 4; l++) begin
            logic [15:0] a = {adr[15:2], 2'(l)};
            if (be[l]) expLog.push_back({a, we, we ? dat[8*l +: 8] : refMem[a]});
        end
        logStart = slaveLog.size();
        applyStimulus(adr, we, be, dat, waitCyc, cycles, rdata, err, glitches, selCycles);
        checkOutput({name, ".cycles"}, cycles, expCycles);
        checkOutput({name, ".rdata"}, rdata, expRdata);
        checkOutput({name, ".err"}, {31'b0, err}, 32'd0);
        checkOutput({name, ".sel_steady"}, glitches, 32'd0);
        checkOutput({name, ".slave_count"}, slaveLog.size() - logStart, expLog.size());
        diffs = 0;
        for (int i = 0; i < expLog.size(); i++)
            if (logStart + i >= slaveLog.size() || slaveLog[logStart + i] !== expLog[i]) diffs++;
        checkOutput({name, ".slave_bytes"}, diffs, 32'd0);
        if (we)
            for (int l = 0; l < 4; l++)
                if (be[l]) refMem[{adr[15:2], 2'(l)}] = dat[8*l +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [11];
        int          cycles, glitches, selCycles, logStart, ackSeen, selSeen;
        logic [31:0] rdata;
        logic        err, found;

        vecs[0]  = '{16'h0104, 1'b1, 4'hF,    32'hA1B2C3D4, 0, 9,  32'h0};
        vecs[1]  = '{16'h0200, 1'b1, 4'b1010, 32'h77AA55BB, 0, 5,  32'h0};
        vecs[2]  = '{16'h0200, 1'b0, 4'b1010, 32'h0,        0, 5,  32'h77005500};
        vecs[3]  = '{16'h0300, 1'b1, 4'h0,    32'hFFFFFFFF, 0, 1,  32'h0};
        vecs[4]  = '{16'h0104, 1'b0, 4'hF,    32'h0,        3, 21, 32'hA1B2C3D4};
        vecs[5]  = '{16'h0302, 1'b1, 4'b0100, 32'h11223344, 0, 3,  32'h0};
        vecs[6]  = '{16'h0300, 1'b0, 4'hF,    32'h0,        1, 13, 32'h00220000};
        vecs[7]  = '{16'h0300, 1'b0, 4'h0,    32'h0,        0, 1,  32'h0};
        vecs[8]  = '{16'h0104, 1'b0, 4'b1001, 32'h0,        2, 9,  32'hA10000D4};
        vecs[9]  = '{16'h0104, 1'b1, 4'b0110, 32'hFFEEDDCC, 0, 5,  32'h0};
        vecs[10] = '{16'h0104, 1'b0, 4'hF,    32'h0,        0, 9,  32'hA1EEDDD4};

        reset_ni = 1'b0; master_sel_i = 1'b1; master_adr_i = 16'h1234;
        master_we_i = 1'b1; master_be_i = 4'hF; master_dat_i = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.outputs", {4'b0, slave_sel_o, slave_we_o, master_ack_o, master_err_o,
                                      slave_dat_o, slave_adr_o}, 32'd0);
        checkOutput("reset.master_dat", master_dat_o, 32'd0);
        master_sel_i = 1'b0;
        reset_ni = 1'b1;

        for (int i = 0; i < 11; i++)
            checkTransfer($sformatf("vec%0d", i), vecs[i].adr, vecs[i].we, vecs[i].be, vecs[i].dat,
                          vecs[i].waitCyc, vecs[i].expCycles, vecs[i].expRdata);

        // Slave never acks: sel held for 8 cycles, then ack with err.
        slaveMute = 1'b1;
        logStart = slaveLog.size();
        applyStimulus(16'h0400, 1'b0, 4'hF, 32'h0, 0, cycles, rdata, err, glitches, selCycles);
        checkOutput("timeout.cycles", cycles, 32'd9);
        checkOutput("timeout.err", {31'b0, err}, 32'd1);
        checkOutput("timeout.sel_cycles", selCycles, 32'd8);
        checkOutput("timeout.slave_count", slaveLog.size() - logStart, 32'd0);
        checkOutput("timeout.rdata", rdata, 32'd0);
        slaveMute = 1'b0;
        checkTransfer("after_timeout", 16'h0104, 1'b0, 4'hF, 32'h0, 0, 9, 32'hA1EEDDD4);

        // Asynchronous reset during lane 2 of a write.
        slaveWait = 0;
        @(posedge clk); #1;
        master_sel_i = 1'b1; master_adr_i = 16'h0500; master_we_i = 1'b1;
        master_be_i = 4'hF; master_dat_i = 32'hDEADBEEF;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (slave_sel_o && slave_adr_o == 16'h0502) found = 1'b1;
        end
        checkOutput("rst_mid.reach_lane2", {31'b0, found}, 32'd1);
        reset_ni = 1'b0; master_sel_i = 1'b0;
        #1;
        checkOutput("rst_mid.outputs", {4'b0, slave_sel_o, slave_we_o, master_ack_o, master_err_o,
                                        slave_dat_o, slave_adr_o}, 32'd0);
        checkOutput("rst_mid.master_dat", master_dat_o, 32'd0);
        @(posedge clk); #1;
        reset_ni = 1'b1;
        ackSeen = 0; selSeen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (master_ack_o) ackSeen++;
            if (slave_sel_o) selSeen++;
        end
        checkOutput("rst_mid.no_ack", ackSeen, 32'd0);
        checkOutput("rst_mid.idle", selSeen, 32'd0);
        refMem[16'h0500] = 8'hEF;
        refMem[16'h0501] = 8'hBE;
        checkTransfer("rst_mid.restart", 16'h0500, 1'b0, 4'hF, 32'h0, 0, 9, 32'h0000BEEF);

        // Master drops sel while lane 0 waits: byte 0 completes, nothing else, no ack.
        slaveWait = 2;
        logStart = slaveLog.size();
        @(posedge clk); #1;
        master_sel_i = 1'b1; master_adr_i = 16'h0600; master_we_i = 1'b1;
        master_be_i = 4'hF; master_dat_i = 32'h11223344;
        @(posedge clk);
        ackSeen = 0; selSeen = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (master_ack_o) ackSeen++;
            if (slave_sel_o) selSeen++;
            if (c == 2) master_sel_i = 1'b0;
            @(posedge clk);
        end
        checkOutput("abort.no_ack", ackSeen, 32'd0);
        checkOutput("abort.sel_cycles", selSeen, 32'd3);
        checkOutput("abort.slave_count", slaveLog.size() - logStart, 32'd1);
        if (slaveLog.size() > logStart)
            checkOutput("abort.slave_byte", {7'b0, slaveLog[logStart]}, {7'b0, 16'h0600, 1'b1, 8'h44});
        refMem[16'h0600] = 8'h44;
        checkTransfer("abort.after", 16'h0600, 1'b0, 4'hF, 32'h0, 0, 9, 32'h00000044);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] adr = 16'h0800 | 16'($urandom_range(0, 63) << 2) | 16'($urandom_range(0, 3));
            logic        we  = 1'($urandom_range(0, 1));
            logic [3:0]  be  = 4'($urandom);
            logic [31:0] dat = $urandom;
            int          w   = $urandom_range(0, 3);
            checkTransfer($sformatf("rand%0d", i), adr, we, be, dat, w,
                          modelCycles(be, w), we ? 32'h0 : modelRead(adr, be));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
